// File: rtl/alu_muldiv_if.sv
// ============================================================================
// Module  : alu_muldiv_if
// Brief   : Request/response bundle for the iterative multiply/divide unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output ready_o, valid_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module  : alu_muldiv
// Brief   : Iterative radix-2 multiplier / restoring divider, one bit per cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_muldiv_if.slave   bus
);
  localparam int                 CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]    MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;

  // Request decode: signedness, magnitudes and divide special cases
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic                is_div, div_zero, div_ovf;

  always_comb begin
    a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
               (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    a_neg    = a_signed && bus.a_i[XLEN-1];
    b_neg    = b_signed && bus.b_i[XLEN-1];
    a_mag    = a_neg ? -bus.a_i : bus.a_i;
    b_mag    = b_neg ? -bus.b_i : bus.b_i;
    is_div   = bus.op_i[2];
    div_zero = (bus.b_i == '0);
    div_ovf  = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
               (bus.a_i == MOST_NEG) && (bus.b_i == '1);
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) special_res = bus.op_i[1] ? bus.a_i : '1;
    else          special_res = bus.op_i[1] ? '0 : bus.a_i;
  end

  // One iteration of shift-add (multiply) or shift-subtract (divide)
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, step, prod;
  logic [XLEN-1:0]     quo, rem, fin;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    step      = op_q[2] ? div_next : mul_next;
    prod      = neg_res_q ? -step : step;
    quo       = step[XLEN-1:0];
    rem       = step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:    fin = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fin = prod[2*XLEN-1:XLEN];
      OP_DIV:    fin = neg_res_q ? -quo : quo;
      OP_DIVU:   fin = quo;
      OP_REM:    fin = neg_rem_q ? -rem : rem;
      OP_REMU:   fin = rem;
      default:   fin = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            op_d      = bus.op_i;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            if (is_div && (div_zero || div_ovf)) begin
              result_d = special_res;
              state_d  = DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              opnd_d  = is_div ? b_mag : a_mag;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = fin;
            cnt_d    = '0;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module  : tb_alu_muldiv
// Brief   : Directed self-checking bench for alu_muldiv at XLEN=32 and XLEN=16.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst16 = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(32)) if32 ();
  alu_muldiv_if #(.XLEN(16)) if16 ();

  alu_muldiv #(.XLEN(32)) u_dut32 (.clk_i(clk), .rst_i(rst32), .bus(if32.slave));
  alu_muldiv #(.XLEN(16)) u_dut16 (.clk_i(clk), .rst_i(rst16), .bus(if16.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit busy_ok;
    bit got;
    n = 0;
    while (!if32.ready_o && n < 100) begin tick(); n++; end
    if32.valid_i = 1'b1; if32.op_i = op; if32.a_i = a; if32.b_i = b;
    tick();
    if32.valid_i = 1'b0; if32.op_i = 3'($urandom); if32.a_i = $urandom; if32.b_i = $urandom;
    n = 1; busy_ok = 1'b1; got = 1'b0;
    while (n <= 100) begin
      if (if32.valid_o) begin got = 1'b1; break; end
      if (if32.ready_o) busy_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, " valid"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " result"}, 64'(if32.result_o), 64'(exp_res));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run16(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res, input int exp_lat);
    int n;
    bit got;
    n = 0;
    while (!if16.ready_o && n < 100) begin tick(); n++; end
    if16.valid_i = 1'b1; if16.op_i = op; if16.a_i = a; if16.b_i = b;
    tick();
    if16.valid_i = 1'b0; if16.a_i = 16'($urandom); if16.b_i = 16'($urandom);
    n = 1; got = 1'b0;
    while (n <= 100) begin
      if (if16.valid_o) begin got = 1'b1; break; end
      tick();
      n++;
    end
    chk({tag, " valid"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " result"}, 64'(if16.result_o), 64'(exp_res));
  endtask

  initial begin
    int  n;
    bit  seen;

    if32.valid_i = 1'b0; if32.op_i = '0; if32.a_i = '0; if32.b_i = '0; if32.flush_i = 1'b0;
    if16.valid_i = 1'b0; if16.op_i = '0; if16.a_i = '0; if16.b_i = '0; if16.flush_i = 1'b0;
    repeat (3) tick();
    rst32 = 1'b0;
    rst16 = 1'b0;

    chk("rst32 ready",  64'(if32.ready_o),  64'd1);
    chk("rst32 valid",  64'(if32.valid_o),  64'd0);
    chk("rst32 result", 64'(if32.result_o), 64'd0);
    chk("rst16 ready",  64'(if16.ready_o),  64'd1);
    chk("rst16 result", 64'(if16.result_o), 64'd0);

    run32("mul 7*6",        3'b000, 32'd7,          32'd6,          32'h0000_002A, 33);
    run32("mulh min*min",   3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33);
    run32("mulhsu -1*max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33);
    run32("mulhu max*max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
    run32("mul max*max",    3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33);
    run32("div -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
    run32("rem -7%2",       3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
    run32("div 7/-2",       3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33);
    run32("divu 5/0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    run32("remu 5/0",       3'b111, 32'd5,          32'd0,          32'd5,         1);
    run32("div ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
    run32("rem ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1);
    run32("divu 100/7",     3'b101, 32'd100,        32'd7,          32'd14,        33);
    run32("remu 100/7",     3'b111, 32'd100,        32'd7,          32'd2,         33);

    // Flush a divide in its tenth CALC cycle
    tick();
    if32.valid_i = 1'b1; if32.op_i = 3'b100; if32.a_i = 32'd1000; if32.b_i = 32'd3;
    tick();
    if32.valid_i = 1'b0;
    n = 1;
    while (n < 10) begin tick(); n++; end
    if32.flush_i = 1'b1;
    tick();
    if32.flush_i = 1'b0;
    chk("flush ready",  64'(if32.ready_o),  64'd1);
    chk("flush valid",  64'(if32.valid_o),  64'd0);
    chk("flush result", 64'(if32.result_o), 64'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if32.valid_o) seen = 1'b1;
      tick();
    end
    chk("flush no valid", 64'(seen), 64'd0);

    run32("mul 3*3", 3'b000, 32'd3, 32'd3, 32'd9, 33);

    // Request coinciding with flush in IDLE must be dropped
    tick();
    if32.valid_i = 1'b1; if32.flush_i = 1'b1; if32.op_i = 3'b100; if32.a_i = 32'd8; if32.b_i = 32'd0;
    tick();
    if32.valid_i = 1'b0; if32.flush_i = 1'b0;
    chk("idle flush ready", 64'(if32.ready_o), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if32.valid_o || !if32.ready_o) seen = 1'b1;
      tick();
    end
    chk("idle flush dropped", 64'(seen), 64'd0);
    chk("idle flush result", 64'(if32.result_o), 64'd9);

    run16("x16 mulhu", 3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("x16 rem -7%2", 3'b110, 16'hFFF9, 16'd2, 16'hFFFF, 17);

    // Reset during the fifth CALC cycle at XLEN=16
    tick();
    if16.valid_i = 1'b1; if16.op_i = 3'b011; if16.a_i = 16'hFFFF; if16.b_i = 16'hFFFF;
    tick();
    if16.valid_i = 1'b0;
    n = 1;
    while (n < 5) begin tick(); n++; end
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    chk("x16 rst result", 64'(if16.result_o), 64'd0);
    chk("x16 rst ready",  64'(if16.ready_o),  64'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (if16.valid_o) seen = 1'b1;
      tick();
    end
    chk("x16 rst no valid", 64'(seen), 64'd0);

    run16("x16 mul 3*5", 3'b000, 16'd3, 16'd5, 16'd15, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 valid_i  input  1  request strobe; operation is accepted on a rising edge where valid_i=1 and ready_o=1.
REQ-005 op_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a_i  input  XLEN  operand A (multiplicand or dividend).
REQ-007 b_i  input  XLEN  operand B (multiplier or divisor).
REQ-008 flush_i  input  1  abort any in-flight operation.
REQ-009 ready_o  output  1  block idle, can accept a request.
REQ-010 valid_o  output  1  one-cycle strobe: result_o is valid.
REQ-011 result_o  output  XLEN  result of the last completed operation.

Function
REQ-012 FSM states: IDLE, CALC, DONE; ready_o=1 only in IDLE; valid_o=1 only in DONE.
REQ-013 IDLE->CALC on accept; IDLE->DONE on accept of a divide-class op hitting a special case (REQ-020/021); CALC->DONE after exactly XLEN CALC cycles (counter 0..XLEN-1); DONE->IDLE unconditionally.
REQ-014 op_i, a_i and b_i are captured at accept; input changes afterwards are ignored until the next accept.
REQ-015 Latency: normal ops drive valid_o in the (XLEN+1)th cycle after the accept cycle; special cases drive it in the 1st cycle after the accept cycle.
REQ-016 Throughput: no request is accepted in CALC or DONE; back-to-back accept is allowed in the cycle after DONE.
REQ-017 Multiply: iterative radix-2, one bit per CALC cycle, over a 2*XLEN-bit product. MUL returns the low XLEN bits. MULH returns the high XLEN bits of signed x signed, MULHSU of signed A x unsigned B, MULHU of unsigned x unsigned.
REQ-018 Divide: iterative restoring, one quotient bit per CALC cycle, operating on magnitudes. The signed quotient is negated when operand signs differ. The signed remainder takes the sign of the dividend. DIVU/REMU are fully unsigned.
REQ-019 Every result is exact modulo 2^XLEN; there is no overflow or exception output.
REQ-020 Divide by zero (b=0): DIV/DIVU return all ones; REM/REMU return A.
REQ-021 Signed overflow (DIV/REM with A=most-negative and B=all ones): DIV returns A; REM returns 0.
REQ-022 result_o updates only in the cycle valid_o rises and holds its value otherwise, including across flush.
REQ-023 flush_i=1 in CALC or DONE: state becomes IDLE at the next edge, no valid_o is issued, and result_o is unchanged. A flush in the DONE cycle does not suppress the already-asserted valid_o.
REQ-024 flush_i=1 in IDLE: no request is accepted that cycle, even if valid_i=1; flush takes priority over accept.
REQ-025 Reset takes priority over flush_i and valid_i.

Reset
REQ-026 While rst_i=1 at an edge, the next state is IDLE: ready_o=1, valid_o=0, result_o=0, counter=0, captured operands=0.
REQ-027 Reset asserted mid-CALC aborts the operation with no valid_o; the first accept is possible in the cycle after rst_i deasserts.

Verification
REQ-028 XLEN=32, MUL a=7 b=6, then MULH a=b=0x80000000 -> 0x0000002A at accept+33; then 0x40000000 at its own accept+33; ready_o=0 throughout each CALC.
REQ-029 MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-030 DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100 b=7 -> 14; REMU same operands -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF at accept+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each at latency 1.
REQ-032 DIV issued, flush_i pulsed in CALC cycle 10 -> no valid_o, ready_o=1 next cycle, result_o unchanged. New MUL 3*3 -> 9 at accept+33. valid_i with flush_i in IDLE -> not accepted.
REQ-033 XLEN=16, MULHU a=b=0xFFFF -> 0xFFFE at accept+17. rst_i asserted in CALC cycle 5 -> result_o=0, valid_o never asserted.
